// File: rtl/q_pkg.sv
// Shared types and constants for the Q-table controller and its helpers.
package q_pkg;
  localparam int Q_W         = 16;
  localparam int FRAC        = 12;
  localparam logic [Q_W-1:0] Q_ONE = 16'h1000;
  localparam int NUM_ACTIONS = 4;

  typedef logic signed [Q_W-1:0] q_t;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, CAPTURE} ctrl_state_t;
endpackage

// File: rtl/q_table_ctrl_if.sv
// Transition, update-core and lookup channels of the Q-table controller.
interface q_table_ctrl_if #(parameter int NUM_STATES = 16);
  import q_pkg::*;
  localparam int SW = $clog2(NUM_STATES);

  logic          tr_valid, tr_ready;
  logic [SW-1:0] tr_state, tr_next_state;
  logic [1:0]    tr_action;
  q_t            tr_reward;
  logic          clear;

  logic          core_start;
  q_t            core_q_current, core_q_next_0, core_q_next_1, core_q_next_2, core_q_next_3;
  q_t            core_reward;
  logic          core_done;
  q_t            core_q_new;

  logic          rd_en;
  logic [SW-1:0] rd_state;
  logic [1:0]    rd_action;
  logic          rd_valid;
  q_t            rd_q;
  logic [1:0]    rd_best_action;

  modport slave (
    input  tr_valid, tr_state, tr_next_state, tr_action, tr_reward, clear,
           core_done, core_q_new, rd_en, rd_state, rd_action,
    output tr_ready, core_start, core_q_current, core_q_next_0, core_q_next_1,
           core_q_next_2, core_q_next_3, core_reward, rd_valid, rd_q, rd_best_action
  );

  modport master (
    output tr_valid, tr_state, tr_next_state, tr_action, tr_reward, clear,
           core_done, core_q_new, rd_en, rd_state, rd_action,
    input  tr_ready, core_start, core_q_current, core_q_next_0, core_q_next_1,
           core_q_next_2, core_q_next_3, core_reward, rd_valid, rd_q, rd_best_action
  );
endinterface

// File: rtl/q_argmax4.sv
// 4-way signed argmax; equal values resolve to the lowest index.
module q_argmax4
  import q_pkg::*;
(
  input  logic [NUM_ACTIONS-1:0][Q_W-1:0] q_i,
  output logic [1:0]                      idx_o
);
  logic lo_sel, hi_sel;
  q_t   lo_max, hi_max;

  // Only a strictly greater upper candidate wins, which keeps ties on the lower index.
  always_comb begin
    lo_sel = $signed(q_i[1]) > $signed(q_i[0]);
    lo_max = lo_sel ? q_i[1] : q_i[0];
    hi_sel = $signed(q_i[3]) > $signed(q_i[2]);
    hi_max = hi_sel ? q_i[3] : q_i[2];
    idx_o  = (hi_max > lo_max) ? {1'b1, hi_sel} : {1'b0, lo_sel};
  end
endmodule

// File: rtl/q_table_ctrl.sv
// Q-table storage and sequencer: fetches operands for the update core and writes back Q_new.
module q_table_ctrl
  import q_pkg::*;
#(
  parameter int NUM_STATES = 16
) (
  input  logic            gclk,
  input  logic            grst_n,
  q_table_ctrl_if.slave   bus,
  output logic            busy_o,
  output logic [15:0]     upd_count_o
);
  localparam int SW = $clog2(NUM_STATES);

  logic [NUM_STATES-1:0][NUM_ACTIONS-1:0][Q_W-1:0] tbl_q;
  ctrl_state_t state_q, state_d;

  logic [SW-1:0]                   s_q, sn_q;
  logic [1:0]                      a_q;
  q_t                              rew_q, qcur_q;
  logic [NUM_ACTIONS-1:0][Q_W-1:0] qnx_q;
  logic [15:0]                     cnt_q;
  logic                            rd_valid_q;
  q_t                              rd_q_q;
  logic [1:0]                      rd_best_q, rd_best;
  logic                            accept;

  // clear wins over a simultaneous offer, so ready drops while clear is high.
  assign bus.tr_ready = grst_n && (state_q == IDLE) && !bus.clear;
  assign accept       = (state_q == IDLE) && !bus.clear && bus.tr_valid;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.core_done) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  q_argmax4 u_amax (.q_i(tbl_q[bus.rd_state]), .idx_o(rd_best));

  // Lookups sample the table before any same-edge write, giving old data on a collision.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      tbl_q      <= '0;
      s_q        <= '0;
      sn_q       <= '0;
      a_q        <= '0;
      rew_q      <= '0;
      qcur_q     <= '0;
      qnx_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_q_q     <= '0;
      rd_best_q  <= '0;
    end else begin
      if (state_q == IDLE && bus.clear) tbl_q <= '0;
      if (accept) begin
        s_q   <= bus.tr_state;
        sn_q  <= bus.tr_next_state;
        a_q   <= bus.tr_action;
        rew_q <= bus.tr_reward;
      end
      if (state_q == FETCH) begin
        qcur_q <= tbl_q[s_q][a_q];
        qnx_q  <= tbl_q[sn_q];
      end
      if (state_q == CAPTURE) begin
        tbl_q[s_q][a_q] <= bus.core_q_new;
        cnt_q           <= cnt_q + 16'd1;
      end
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_q_q    <= tbl_q[bus.rd_state][bus.rd_action];
        rd_best_q <= rd_best;
      end
    end
  end

  assign bus.core_start     = (state_q == ISSUE);
  assign bus.core_q_current = qcur_q;
  assign bus.core_q_next_0  = qnx_q[0];
  assign bus.core_q_next_1  = qnx_q[1];
  assign bus.core_q_next_2  = qnx_q[2];
  assign bus.core_q_next_3  = qnx_q[3];
  assign bus.core_reward    = rew_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_q           = rd_q_q;
  assign bus.rd_best_action = rd_best_q;
  assign busy_o             = (state_q != IDLE);
  assign upd_count_o        = cnt_q;
endmodule
